// File: rtl/mem_io_responder_if.sv
// CPU-side byte memory bus plus the UART-facing transmit handshake and
// sticky status flags of the memory/IO responder.
interface mem_io_responder_if;
   logic        rdy;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_overflow;
   logic        halt;

   modport slave (
      input  rdy, mem_a, mem_dout, mem_wr, tx_ready,
      output mem_din, tx_data, tx_valid, tx_overflow, halt
   );

   modport master (
      output rdy, mem_a, mem_dout, mem_wr, tx_ready,
      input  mem_din, tx_data, tx_valid, tx_overflow, halt
   );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: on-chip RAM when mem_a[17]=0, otherwise an IO
// window with a UART transmit FIFO, a status register and a halt register.
module mem_io_responder #(
   parameter int RAM_AW  = 17,
   parameter int FIFO_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_io_responder_if.slave bus
);
   localparam int RAM_DEPTH  = 1 << RAM_AW;
   localparam int FIFO_DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);
   localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

   typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_IO} rd_src_e;

   logic [7:0] ram_mem [RAM_DEPTH];
   logic [7:0] ram_rd_q;
   logic [7:0] fifo_mem [FIFO_DEPTH];

   rd_src_e            rd_src_q, rd_src_d;
   logic [7:0]         io_rd_q, io_rd_d;
   logic [FIFO_AW-1:0] head_q, head_d;
   logic [FIFO_AW-1:0] tail_q, tail_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               halt_q, halt_d;

   logic [RAM_AW-1:0]  ram_addr;
   logic [2:0]         io_off;
   logic               io_sel, ram_we, push_req, push_ok, pop, fifo_full, halt_wr;
   logic               unused_addr_bits;

   assign ram_addr         = bus.mem_a[RAM_AW-1:0];
   assign io_sel           = bus.mem_a[17];
   assign io_off           = bus.mem_a[2:0];
   assign unused_addr_bits = ^bus.mem_a[31:18];

   assign ram_we    = bus.rdy & bus.mem_wr & ~io_sel;
   assign push_req  = bus.rdy & bus.mem_wr & io_sel & (io_off == 3'd0);
   assign halt_wr   = bus.rdy & bus.mem_wr & io_sel & (io_off == 3'd4);
   assign fifo_full = (count_q == FULL_COUNT);
   // Pop side runs regardless of rdy; a pop frees the slot a same-cycle push needs.
   assign pop       = (count_q != '0) & bus.tx_ready;
   assign push_ok   = push_req & (~fifo_full | pop);

   always_comb begin
      rd_src_d   = rd_src_q;
      io_rd_d    = io_rd_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      halt_d     = halt_q;

      if (bus.rdy) begin
         if (bus.mem_wr) begin
            rd_src_d = SRC_ZERO;
         end else if (io_sel) begin
            rd_src_d = SRC_IO;
         end else begin
            rd_src_d = SRC_RAM;
         end
         io_rd_d = (io_off == 3'd4) ? {6'b0, overflow_q, fifo_full} : 8'h00;
      end

      if (pop) begin
         head_d = head_q + PTR_ONE;
      end
      if (push_ok) begin
         tail_d = tail_q + PTR_ONE;
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (push_req && !push_ok) begin
         overflow_d = 1'b1;
      end
      if (halt_wr) begin
         halt_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_src_q   <= SRC_ZERO;
         io_rd_q    <= 8'h00;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         rd_src_q   <= rd_src_d;
         io_rd_q    <= io_rd_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         halt_q     <= halt_d;
      end
   end

   // Storage arrays carry no reset so they map onto RAM primitives.
   always_ff @(posedge clk) begin
      if (bus.rdy) begin
         if (ram_we) begin
            ram_mem[ram_addr] <= bus.mem_dout;
         end
         ram_rd_q <= ram_mem[ram_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[tail_q] <= bus.mem_dout;
      end
   end

   always_comb begin
      case (rd_src_q)
         SRC_RAM: bus.mem_din = ram_rd_q;
         SRC_IO:  bus.mem_din = io_rd_q;
         default: bus.mem_din = 8'h00;
      endcase
   end

   assign bus.tx_valid    = (count_q != '0);
   assign bus.tx_data     = bus.tx_valid ? fifo_mem[head_q] : 8'h00;
   assign bus.tx_overflow = overflow_q;
   assign bus.halt        = halt_q;
endmodule
